// File: rtl/uart_tx_queue.sv
// uart_tx_queue: byte FIFO plus issue controller feeding a UART transmitter (start/busy handshake).
// Define UART_TXQ_FLUSH_EN to add a synchronous flush input that empties the queue.
//
// state | meaning
// IDLE  | waiting for a queued byte and an idle transmitter
// ISSUE | byte presented, tx_start held until transmitter reports busy
// DRAIN | transmitter busy with current byte, waiting for it to finish
module uart_tx_queue #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef UART_TXQ_FLUSH_EN
    input  logic          flush,
`endif
    input  logic [7:0]    s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [7:0]    tx_data_in,
    output logic          tx_start,
    input  logic          tx_busy,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
);

    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_ISSUE = 2'd1;
    localparam logic [1:0]  ST_DRAIN = 2'd2;
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          flush_w;
    logic          push_w;
    logic          pop_w;

`ifdef UART_TXQ_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_LVL);
    assign level      = count_q;
    // No bypass: a pop in the same cycle does not open a slot while full.
    assign s_ready    = !full && !flush_w;
    assign tx_start   = tx_start_q;
    assign tx_data_in = tx_data_q;

    assign push_w = s_valid && s_ready;
    assign pop_w  = (state_q == ST_IDLE) && !empty && !tx_busy && !flush_w;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_w) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_w) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop_w) begin
                rptr_d = rptr_q + AW'(1);
            end
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_w) begin
                    tx_data_d  = mem_q[rptr_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                tx_start_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wptr_q] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Directed bench for uart_tx_queue with a behavioural transmitter (busy 1 cycle after start, 20 cycles long).
// Flush scenario is exercised only when UART_TXQ_FLUSH_EN is defined.
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] tx_data_in;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] level;
    logic       empty;
    logic       full;
`ifdef UART_TXQ_FLUSH_EN
    logic       flush = 1'b0;
`endif

    logic       busy_hold = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] rx_q [$];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    uart_tx_queue #(.DEPTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef UART_TXQ_FLUSH_EN
        .flush      (flush),
`endif
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .tx_data_in (tx_data_in),
        .tx_start   (tx_start),
        .tx_busy    (tx_busy),
        .level      (level),
        .empty      (empty),
        .full       (full)
    );

    always #5 clk = ~clk;

    // Transmitter model: latches the byte on the first edge it sees tx_start, busy for 20 cycles after.
    assign tx_busy = busy_hold || (busy_cnt != 0);

    always @(posedge clk) begin
        if (!rst_n) begin
            busy_cnt <= 0;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end else if (tx_start) begin
            busy_cnt <= 20;
            rx_q.push_back(tx_data_in);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        int g = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        check("push_timeout", 32'(g < 2000), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget, input string tag);
        int n = 0;
        while (!(empty && !tx_busy && !tx_start) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(tx_busy && !tx_start) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < 20), 32'd1);
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i),
                  (i < rx_q.size()) ? 32'(rx_q[i]) : 32'h1FF, 32'(exp_q[i]));
        end
    endtask

    initial begin
        // Reset held for three clocks
        repeat (3) @(negedge clk);
        check("rst_level", 32'(level), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data_in), 32'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Single byte: accepted at N, start after N+1, dropped once busy is seen
        rx_q.delete();
        push(8'hA5);
        check("single_level_after_push", 32'(level), 32'd1);
        check("single_no_start_yet", 32'(tx_start), 32'd0);
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'd1);
        check("single_data", 32'(tx_data_in), 32'hA5);
        check("single_empty", 32'(empty), 32'd1);
        @(negedge clk);
        check("single_start_held", 32'(tx_start), 32'd1);
        @(negedge clk);
        check("single_start_dropped", 32'(tx_start), 32'd0);
        check("single_data_stable", 32'(tx_data_in), 32'hA5);
        wait_quiet(100, "single_quiet");
        exp_q.delete();
        exp_q.push_back(8'hA5);
        compare_rx("single_rx");

        // Fill to DEPTH while the transmitter is held busy; 17th push refused
        rx_q.delete();
        busy_hold = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("fill_full", 32'(full), 32'd1);
        check("fill_s_ready", 32'(s_ready), 32'd0);
        check("fill_level", 32'(level), 32'd16);
        s_data  = 8'hEE;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("fill_17th_refused", 32'(level), 32'd16);
        busy_hold = 1'b0;
        wait_quiet(600, "fill_quiet");
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
        compare_rx("fill_rx");

        // Push and pop on the same edge at level 3, then 40 bytes streamed through the wrap
        rx_q.delete();
        busy_hold = 1'b1;
        push(8'h10);
        push(8'h11);
        push(8'h12);
        check("pp_level_before", 32'(level), 32'd3);
        busy_hold = 1'b0;
        s_data  = 8'h13;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        check("pp_level_same", 32'(level), 32'd3);
        check("pp_start", 32'(tx_start), 32'd1);
        check("pp_data", 32'(tx_data_in), 32'h10);
        for (int i = 0; i < 40; i++) push(8'h40 + 8'(i));
        wait_quiet(2000, "wrap_quiet");
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 40; i++) exp_q.push_back(8'h40 + 8'(i));
        compare_rx("wrap_rx");

        // Reset in DRAIN with five bytes queued abandons everything
        push(8'h77);
        wait_drain("rst_drain_reach");
        for (int i = 0; i < 5; i++) push(8'h80 + 8'(i));
        check("rst_drain_level", 32'(level), 32'd5);
        check("rst_drain_busy", 32'(tx_busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_level", 32'(level), 32'd0);
        check("rst_mid_empty", 32'(empty), 32'd1);
        check("rst_mid_tx_start", 32'(tx_start), 32'd0);
        check("rst_mid_tx_data", 32'(tx_data_in), 32'h00);
        rst_n = 1'b1;
        rx_q.delete();
        push(8'h99);
        @(negedge clk);
        check("rst_idle_start", 32'(tx_start), 32'd1);
        check("rst_idle_data", 32'(tx_data_in), 32'h99);
        wait_quiet(100, "rst_quiet");
        exp_q.delete();
        exp_q.push_back(8'h99);
        compare_rx("rst_rx");

`ifdef UART_TXQ_FLUSH_EN
        // Flush at level 6 in DRAIN together with a push: queue emptied, push dropped, current byte finishes
        rx_q.delete();
        push(8'h21);
        wait_drain("flush_drain_reach");
        for (int i = 0; i < 6; i++) push(8'h30 + 8'(i));
        check("flush_level_before", 32'(level), 32'd6);
        flush   = 1'b1;
        s_data  = 8'hBB;
        s_valid = 1'b1;
        #1;
        check("flush_s_ready", 32'(s_ready), 32'd0);
        @(negedge clk);
        flush   = 1'b0;
        s_valid = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_busy_continues", 32'(tx_busy), 32'd1);
        wait_quiet(100, "flush_quiet");
        repeat (5) @(negedge clk);
        check("flush_no_start", 32'(tx_start), 32'd0);
        exp_q.delete();
        exp_q.push_back(8'h21);
        compare_rx("flush_rx");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
